// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: UART 8N1 receiver (8E1 when UART_CMD_RX_PARITY_EN is defined) with G/Y/R/X command decode.
// Latency: strobes one clock after the stop-bit sample, i.e. t0 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 (+CLKS_PER_BIT with parity).
// Backpressure: none; byte_valid/cmd_valid/frame_err are single-cycle strobes the sequencer must take as they come.
module uart_cmd_rx #(
  parameter int CLK_HZ       = 12000000,
  parameter int BAUD         = 9600,
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] pc_input,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       cmd_valid,
  output logic [1:0] cmd_code,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_CMD_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_HI
  } state_t;

  state_t           r_state;
  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_baud_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_fin_good;
  logic             r_fin_bad;
  logic [7:0]       r_pc_input;
  logic [7:0]       r_byte_data;
  logic             r_byte_valid;
  logic             r_frame_err;
  logic             r_cmd_valid;
  logic [1:0]       r_cmd_code;
  logic             r_busy;
`ifdef UART_CMD_RX_PARITY_EN
  logic             r_par;
  logic             r_par_bad;
`endif

  logic       w_rx_s;
  logic       w_half;
  logic       w_full;
  logic       w_is_cmd;
  logic [1:0] w_code;

  assign w_rx_s = r_sync[1];
  assign w_half = (r_baud_cnt == HALF_CNT);
  assign w_full = (r_baud_cnt == FULL_CNT);

  assign pc_input   = r_pc_input;
  assign byte_data  = r_byte_data;
  assign byte_valid = r_byte_valid;
  assign frame_err  = r_frame_err;
  assign cmd_valid  = r_cmd_valid;
  assign cmd_code   = r_cmd_code;
  assign busy       = r_busy;

  // Two-flop synchroniser for the asynchronous serial line; resets to idle-high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= 2'b11;
    else     r_sync <= {r_sync[0], rx};
  end

  // Exact uppercase match on the completed character
  always_comb begin
    w_is_cmd = 1'b1;
    w_code   = 2'b00;
    case (r_shift)
      8'h47:   w_code = 2'b00;
      8'h59:   w_code = 2'b01;
      8'h52:   w_code = 2'b10;
      8'h58:   w_code = 2'b11;
      default: w_is_cmd = 1'b0;
    endcase
  end

  // Receive FSM; frame verdict is latched at the stop sample and published one clock later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_baud_cnt   <= '0;
      r_bit_idx    <= 3'd0;
      r_shift      <= 8'h00;
      r_fin_good   <= 1'b0;
      r_fin_bad    <= 1'b0;
      r_pc_input   <= 8'h00;
      r_byte_data  <= 8'h00;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_cmd_valid  <= 1'b0;
      r_cmd_code   <= 2'b00;
      r_busy       <= 1'b0;
`ifdef UART_CMD_RX_PARITY_EN
      r_par        <= 1'b0;
      r_par_bad    <= 1'b0;
`endif
    end else begin
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_cmd_valid  <= 1'b0;
      r_pc_input   <= 8'h00;
      r_fin_good   <= 1'b0;
      r_fin_bad    <= 1'b0;

      // r_shift is stable here: the FSM cannot reach DATA again within one clock of STOP
      if (r_fin_good) begin
        r_byte_valid <= 1'b1;
        r_pc_input   <= r_shift;
        r_byte_data  <= r_shift;
        if (w_is_cmd) begin
          r_cmd_valid <= 1'b1;
          r_cmd_code  <= w_code;
        end
      end
      if (r_fin_bad) r_frame_err <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (!w_rx_s) begin
            r_baud_cnt <= '0;
            r_busy     <= 1'b1;
            r_state    <= S_START;
          end
        end
        S_START: begin
          if (w_half) begin
            r_baud_cnt <= '0;
            if (!w_rx_s) begin
              r_bit_idx <= 3'd0;
`ifdef UART_CMD_RX_PARITY_EN
              r_par     <= 1'b0;
`endif
              r_state   <= S_DATA;
            end else begin
              // Line was high again mid-start-bit: treat as a glitch
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (w_full) begin
            r_baud_cnt <= '0;
            r_shift    <= {w_rx_s, r_shift[7:1]};
`ifdef UART_CMD_RX_PARITY_EN
            r_par      <= r_par ^ w_rx_s;
`endif
            if (r_bit_idx == 3'd7) begin
              r_bit_idx <= 3'd0;
`ifdef UART_CMD_RX_PARITY_EN
              r_state   <= S_PARITY;
`else
              r_state   <= S_STOP;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + CNT_W'(1);
          end
        end
`ifdef UART_CMD_RX_PARITY_EN
        S_PARITY: begin
          if (w_full) begin
            r_baud_cnt <= '0;
            // Even parity: data bits plus parity bit must XOR to zero
            r_par_bad  <= r_par ^ w_rx_s;
            r_state    <= S_STOP;
          end else begin
            r_baud_cnt <= r_baud_cnt + CNT_W'(1);
          end
        end
`endif
        S_STOP: begin
          if (w_full) begin
            r_baud_cnt <= '0;
            if (w_rx_s) begin
`ifdef UART_CMD_RX_PARITY_EN
              r_fin_good <= ~r_par_bad;
              r_fin_bad  <= r_par_bad;
`else
              r_fin_good <= 1'b1;
`endif
              r_busy     <= 1'b0;
              r_state    <= S_IDLE;
            end else begin
              r_fin_bad <= 1'b1;
              r_state   <= S_WAIT_HI;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + CNT_W'(1);
          end
        end
        S_WAIT_HI: begin
          // Hold off through a break until the line idles high
          if (w_rx_s) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb_uart_cmd_rx: table of characters plus hand sequences for glitch, break, back-to-back and reset.
// Bit period scaled to 100 clocks so the run stays short; all timing derived from CPB.
// Expected strobes are queued before each frame is driven and popped when the DUT pulses.
module tb_uart_cmd_rx;

  localparam int CPB    = 100;
  localparam int BAUD   = 9600;
  localparam int CLK_HZ = CPB * BAUD;
`ifdef UART_CMD_RX_PARITY_EN
  localparam int NBITS  = 10;
`else
  localparam int NBITS  = 9;
`endif
  // 2 synchroniser flops + IDLE detection edge, half start bit, data/parity/stop bits, output register
  localparam int LAT    = 3 + CPB / 2 + NBITS * CPB + 1;
  localparam int FRAME  = (NBITS + 1) * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] pc_input;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       frame_err;
  logic       cmd_valid;
  logic [1:0] cmd_code;
  logic       busy;

  uart_cmd_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .pc_input(pc_input), .byte_data(byte_data), .byte_valid(byte_valid),
    .frame_err(frame_err), .cmd_valid(cmd_valid), .cmd_code(cmd_code), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pc;
    logic [7:0] bdata;
    logic       cmd;
    logic [1:0] code;
    logic       err;
  } exp_t;

  typedef struct {
    logic [7:0] ch;
    logic       cmd;
    logic [1:0] code;
  } vec_t;

  exp_t sb[$];
  exp_t e;
  vec_t tbl[8];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t_fall = 0;
  int bv_cnt = 0;
  int fe_cnt = 0;
  int last_bv_cyc = 0;
  int prev_bv_cyc = 0;
  logic p_bv = 1'b0;
  logic p_fe = 1'b0;
  logic p_cv = 1'b0;
`ifdef UART_CMD_RX_PARITY_EN
  logic par_flip = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drives one frame starting at a negedge; leaves rx at stop_val after stop_bits bit times
  task automatic send_frame(input logic [7:0] d, input logic stop_val, input int stop_bits);
    rx = 1'b0;
    t_fall = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_CMD_RX_PARITY_EN
    rx = (^d) ^ par_flip;
    repeat (CPB) @(negedge clk);
`endif
    rx = stop_val;
    repeat (stop_bits * CPB) @(negedge clk);
  endtask

  // Scoreboard side: pop on every strobe, plus one-cycle pulse rules
  always @(negedge clk) begin
    if (rst) begin
      p_bv = 1'b0;
      p_fe = 1'b0;
      p_cv = 1'b0;
    end else begin
      if (p_bv) begin
        chk("bv_one_cycle", byte_valid, 0);
        chk("pc_input_cleared", pc_input, 0);
      end
      if (p_fe) chk("fe_one_cycle", frame_err, 0);
      if (p_cv) chk("cv_one_cycle", cmd_valid, 0);
      if (cmd_valid) chk("cv_with_bv", byte_valid, 1);
      if (byte_valid || frame_err) begin
        if (byte_valid) begin
          bv_cnt++;
          prev_bv_cyc = last_bv_cyc;
          last_bv_cyc = cyc;
        end
        if (frame_err) fe_cnt++;
        if (sb.size() == 0) begin
          chk("unexpected_bv", byte_valid, 0);
          chk("unexpected_fe", frame_err, 0);
        end else begin
          e = sb.pop_front();
          chk("byte_valid", byte_valid, !e.err);
          chk("frame_err", frame_err, e.err);
          chk("pc_input", pc_input, e.pc);
          chk("byte_data", byte_data, e.bdata);
          chk("cmd_valid", cmd_valid, e.cmd);
          chk("cmd_code", cmd_code, e.code);
        end
      end
      p_bv = byte_valid;
      p_fe = frame_err;
      p_cv = cmd_valid;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{8'h47, 1'b1, 2'd0};
    tbl[1] = '{8'h41, 1'b0, 2'd0};
    tbl[2] = '{8'h59, 1'b1, 2'd1};
    tbl[3] = '{8'h67, 1'b0, 2'd1};
    tbl[4] = '{8'h58, 1'b1, 2'd3};
    tbl[5] = '{8'h00, 1'b0, 2'd3};
    tbl[6] = '{8'h52, 1'b1, 2'd2};
    tbl[7] = '{8'h5A, 1'b0, 2'd2};

    rst = 1'b0;
    rx  = 1'b1;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_pc_input", pc_input, 0);
    chk("rst_byte_data", byte_data, 0);
    chk("rst_byte_valid", byte_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd_code", cmd_code, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Character table: good frames, commands and non-commands
    for (int i = 0; i < 8; i++) begin
      sb.push_back('{pc: tbl[i].ch, bdata: tbl[i].ch, cmd: tbl[i].cmd, code: tbl[i].code, err: 1'b0});
      send_frame(tbl[i].ch, 1'b1, 1);
      chk("table_bv_count", bv_cnt, i + 1);
      if (i == 0) chk("latency_first", last_bv_cyc - t_fall, LAT);
      repeat (3) @(negedge clk);
    end

    // Short low glitch rejected at the start-bit sample
    rx = 1'b0;
    repeat (10) @(negedge clk);
    chk("glitch_busy_hi", busy, 1);
    repeat (14) @(negedge clk);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
    chk("glitch_busy_lo", busy, 0);
    chk("glitch_no_bv", bv_cnt, 8);
    chk("glitch_no_fe", fe_cnt, 0);

    // Stop bit low, line held low as a break for 3 bit times
    sb.push_back('{pc: 8'h00, bdata: 8'h5A, cmd: 1'b0, code: 2'd2, err: 1'b1});
    send_frame(8'h52, 1'b0, 3);
    chk("break_busy_hi", busy, 1);
    chk("break_fe_count", fe_cnt, 1);
    chk("break_no_bv", bv_cnt, 8);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    chk("break_busy_lo", busy, 0);
    sb.push_back('{pc: 8'h58, bdata: 8'h58, cmd: 1'b1, code: 2'd3, err: 1'b0});
    send_frame(8'h58, 1'b1, 1);
    chk("x_after_break", cmd_code, 3);

    // Back-to-back R then Y, no idle gap
    sb.push_back('{pc: 8'h52, bdata: 8'h52, cmd: 1'b1, code: 2'd2, err: 1'b0});
    sb.push_back('{pc: 8'h59, bdata: 8'h59, cmd: 1'b1, code: 2'd1, err: 1'b0});
    send_frame(8'h52, 1'b1, 1);
    send_frame(8'h59, 1'b1, 1);
    chk("b2b_bv_count", bv_cnt, 11);
    chk("b2b_gap", last_bv_cyc - prev_bv_cyc, FRAME);
    repeat (3) @(negedge clk);

    // Reset in the middle of data bit 4
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = (i % 2 == 0);
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    chk("midframe_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("midrst_pc_input", pc_input, 0);
    chk("midrst_byte_data", byte_data, 0);
    chk("midrst_byte_valid", byte_valid, 0);
    chk("midrst_frame_err", frame_err, 0);
    chk("midrst_cmd_valid", cmd_valid, 0);
    chk("midrst_cmd_code", cmd_code, 0);
    chk("midrst_busy", busy, 0);
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    sb.push_back('{pc: 8'h47, bdata: 8'h47, cmd: 1'b1, code: 2'd0, err: 1'b0});
    send_frame(8'h47, 1'b1, 1);
    chk("post_rst_bv_count", bv_cnt, 12);
    chk("latency_post_rst", last_bv_cyc - t_fall, LAT);
    repeat (3) @(negedge clk);

`ifdef UART_CMD_RX_PARITY_EN
    // 'G' with odd parity: stop is good but the frame is rejected
    par_flip = 1'b1;
    sb.push_back('{pc: 8'h00, bdata: 8'h47, cmd: 1'b0, code: 2'd0, err: 1'b1});
    send_frame(8'h47, 1'b1, 1);
    par_flip = 1'b0;
    chk("parity_fe_count", fe_cnt, 2);
    chk("parity_no_bv", bv_cnt, 12);
    repeat (3) @(negedge clk);
`endif

    repeat (20) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
